// File: rtl/bus_rr_arbit.sv
// Four-master round-robin bus arbiter with registered one-hot grants.
// Define BUS_RR_ARBIT_TIMEOUT_EN to force release after TIMEOUT owned cycles.
module bus_rr_arbit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       m3_req,
  output logic       m0_grant,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       m3_grant,
  output logic [1:0] grant_id,
  output logic       bus_busy,
  output logic       timeout_flag
);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t     state;
  logic [3:0] req;
  logic [3:0] grant_q;
  logic [1:0] last_id;
  logic [1:0] pick_id;
  logic       pick_found;
  logic       owner_req;
  logic [3:0] pick_onehot;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_rr_arbit: TIMEOUT must lie in 2..255");
  end

  assign req       = {m3_req, m2_req, m1_req, m0_req};
  assign owner_req = |(req & grant_q);

  // Search last_id+1 .. last_id+4, so the previous owner always ranks last.
  always_comb begin
    logic [1:0] idx;
    idx        = 2'd0;
    pick_found = 1'b0;
    pick_id    = last_id;
    for (int i = 1; i <= 4; i++) begin
      idx = last_id + 2'(i);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign pick_onehot = 4'b0001 << pick_id;

`ifdef BUS_RR_ARBIT_TIMEOUT_EN
  localparam logic [7:0] TENURE_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tenure;
  logic       timeout_q;

  assign timeout_flag = timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant_q   <= 4'b0000;
      grant_id  <= 2'd0;
      bus_busy  <= 1'b0;
      last_id   <= 2'd3;
      tenure    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= OWN;
            grant_q  <= pick_onehot;
            grant_id <= pick_id;
            bus_busy <= 1'b1;
            last_id  <= pick_id;
            tenure   <= 8'd0;
          end
        end
        OWN: begin
          if (owner_req && tenure != TENURE_LAST) begin
            if (tenure != 8'hFF)
              tenure <= tenure + 8'd1;
          end else if (pick_found) begin
            // Either a voluntary release or an eviction; the owner is still
            // eligible after an eviction but ranks behind everyone else.
            timeout_q <= owner_req;
            grant_q   <= pick_onehot;
            grant_id  <= pick_id;
            last_id   <= pick_id;
            tenure    <= 8'd0;
          end else begin
            state    <= IDLE;
            grant_q  <= 4'b0000;
            grant_id <= 2'd0;
            bus_busy <= 1'b0;
            tenure   <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout_flag = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant_q  <= 4'b0000;
      grant_id <= 2'd0;
      bus_busy <= 1'b0;
      last_id  <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= OWN;
            grant_q  <= pick_onehot;
            grant_id <= pick_id;
            bus_busy <= 1'b1;
            last_id  <= pick_id;
          end
        end
        OWN: begin
          if (owner_req) begin
            grant_q <= grant_q;
          end else if (pick_found) begin
            grant_q  <= pick_onehot;
            grant_id <= pick_id;
            last_id  <= pick_id;
          end else begin
            state    <= IDLE;
            grant_q  <= 4'b0000;
            grant_id <= 2'd0;
            bus_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

  assign m0_grant = grant_q[0];
  assign m1_grant = grant_q[1];
  assign m2_grant = grant_q[2];
  assign m3_grant = grant_q[3];

endmodule

// File: tb/tb_bus_rr_arbit.sv
// Directed bench for bus_rr_arbit; expectations depend on BUS_RR_ARBIT_TIMEOUT_EN.
module tb_bus_rr_arbit;

  logic       clk;
  logic       reset_n;
  logic       m0_req, m1_req, m2_req, m3_req;
  logic       m0_grant, m1_grant, m2_grant, m3_grant;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       timeout_flag;

  int vec_count;
  int err_count;

  bus_rr_arbit #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m0_req      (m0_req),
    .m1_req      (m1_req),
    .m2_req      (m2_req),
    .m3_req      (m3_req),
    .m0_grant    (m0_grant),
    .m1_grant    (m1_grant),
    .m2_grant    (m2_grant),
    .m3_grant    (m3_grant),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] r);
    {m3_req, m2_req, m1_req, m0_req} = r;
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_grant,
                             input logic [1:0] exp_id, input logic exp_busy,
                             input logic exp_flag);
    logic [7:0] observed;
    logic [7:0] expected;
    observed = {m3_grant, m2_grant, m1_grant, m0_grant, grant_id, bus_busy, timeout_flag};
    expected = {exp_grant, exp_id, exp_busy, exp_flag};
    vec_count++;
    assert (observed === expected)
    else begin
      err_count++;
      $error("[TB] FAIL %s: observed grants=%b id=%0d busy=%b flag=%b, expected grants=%b id=%0d busy=%b flag=%b",
             tag, observed[7:4], observed[3:2], observed[1], observed[0],
             exp_grant, exp_id, exp_busy, exp_flag);
    end
  endtask

  initial begin
    logic [3:0] all_but;
    vec_count = 0;
    err_count = 0;
    reset_n   = 1'b0;
    applyStimulus(4'b0000);

    #12;
    checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);

    applyStimulus(4'b0001);
    cycle();
    checkOutput("held_in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("no_edge_yet", 4'b0000, 2'd0, 1'b0, 1'b0);

    cycle();
    checkOutput("first_grant_m0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Rotate through all four owners, each holding three cycles.
    applyStimulus(4'b1111);
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < 2; h++) begin
        cycle();
        checkOutput("rr_hold", 4'b0001 << k, 2'(k), 1'b1, 1'b0);
      end
      all_but = 4'b1111 & ~(4'b0001 << k);
      applyStimulus(all_but);
      cycle();
      checkOutput("rr_handoff", 4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4), 1'b1, 1'b0);
      applyStimulus(4'b1111);
    end

    applyStimulus(4'b0100);
    cycle();
    checkOutput("m2_wins", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0110);
    cycle();
    checkOutput("m2_no_preempt_a", 4'b0100, 2'd2, 1'b1, 1'b0);
    cycle();
    checkOutput("m2_no_preempt_b", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0010);
    cycle();
    checkOutput("m1_after_m2", 4'b0010, 2'd1, 1'b1, 1'b0);

    applyStimulus(4'b0000);
    cycle();
    checkOutput("back_to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // last_id=1, so m3 is searched before m0.
    applyStimulus(4'b1001);
    cycle();
    checkOutput("m3_wins", 4'b1000, 2'd3, 1'b1, 1'b0);
`ifdef BUS_RR_ARBIT_TIMEOUT_EN
    for (int h = 0; h < 3; h++) begin
      cycle();
      checkOutput("m3_tenure", 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    cycle();
    checkOutput("timeout_to_m0", 4'b0001, 2'd0, 1'b1, 1'b1);
    cycle();
    checkOutput("flag_one_pulse", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
    for (int h = 0; h < 105; h++) begin
      cycle();
      checkOutput("m3_unlimited", 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    applyStimulus(4'b0001);
    cycle();
    checkOutput("m0_after_m3", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

    applyStimulus(4'b0010);
    cycle();
    checkOutput("m1_owns", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0110);
    cycle();
    checkOutput("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    checkOutput("m1_after_reset", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbit.md
BUS_RR_ARBIT -- requirements
Module: bus_rr_arbit

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum grant tenure in cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 m0_req, m1_req, m2_req, m3_req  input  1 each  master bus requests, level-held.
REQ-005 m0_grant, m1_grant, m2_grant, m3_grant  output  1 each  registered one-hot grants.
REQ-006 grant_id  output  2  index of the granted master; valid only while bus_busy=1.
REQ-007 bus_busy  output  1  high while any grant is asserted.
REQ-008 timeout_flag  output  1  one-cycle pulse on a forced release.

Function
REQ-009 Two states: IDLE (no grant) and OWN (exactly one grant); all outputs registered.
REQ-010 At most one grant SHALL be high in any cycle.
REQ-011 Priority pointer last_id (2 bits) holds the most recently granted index; search order is last_id+1, +2, +3, +4, modulo 4.
REQ-012 IDLE, any req high at the edge -> OWN; grant the first requester in search order; last_id updated to the winner.
REQ-013 IDLE, no req -> stay IDLE; grants, bus_busy and grant_id SHALL be 0.
REQ-014 OWN, owner req still high (and no timeout) -> hold grant; later requests from other masters SHALL NOT pre-empt.
REQ-015 OWN, owner req low at the edge -> re-arbitrate at the same edge, with no idle bubble: the next requester in search order is granted, or IDLE if none.
REQ-016 A released master requesting again at the same edge SHALL rank last in search order.
REQ-017 Grant latency: a req first seen high at edge N into IDLE SHALL produce its grant after edge N (visible in cycle N+1).
REQ-018 Tenure counter (8 bits) SHALL clear on every new grant and increment each OWN cycle; it saturates and does not wrap.
REQ-019 grant_id SHALL equal the encoded index of the active grant; s_wr, s_addr and s_din mux selection downstream use grant_id.

Reset
REQ-020 While reset_n=0, regardless of clk: state=IDLE, all grants=0, grant_id=0, bus_busy=0, timeout_flag=0, tenure=0, last_id=3 (so m0 wins first).
REQ-021 Reset asserted mid-tenure SHALL drop the grant immediately, without waiting for a clock edge.
REQ-022 The first arbitration SHALL occur at the first rising edge after reset_n deasserts.

Configuration
REQ-023 Macro BUS_RR_ARBIT_TIMEOUT_EN compiled in: when tenure reaches TIMEOUT-1 with owner req still high, the next edge SHALL force release.
REQ-024 On a forced release, timeout_flag SHALL pulse for one cycle and re-arbitration SHALL follow REQ-015/REQ-016, with the evicted master ranked last.
REQ-025 Macro absent: tenure is unlimited, the tenure counter SHALL be omitted, and timeout_flag is tied to 0.

Verification
REQ-026 Reset, then m0_req=1 alone -> m0_grant=1, grant_id=0, bus_busy=1 one cycle after the first edge.
REQ-027 m0..m3 all held high, each dropping req after 3 owned cycles and then re-raising it -> grant order 0,1,2,3,0 with no idle cycle between owners.
REQ-028 m2 owns; m1 raises req mid-tenure -> m2 keeps the grant until m2_req=0, then m1_grant=1 at the same edge.
REQ-029 With BUS_RR_ARBIT_TIMEOUT_EN and TIMEOUT=4, m3 and m0 both held high -> m3 is released after 4 owned cycles, timeout_flag pulses once, and m0 is granted; without the macro, m3 keeps the grant for 100+ cycles.
REQ-030 reset_n pulsed low while m1 owns -> all grants drop asynchronously; after release, with m1 and m2 requesting, m1 (search from last_id=3: 0,1,...) is granted.
